// File: rtl/mem_stream_reader.sv
// Burst reader: streams `length` words from a synchronous RAM starting at base_addr,
// through a 3-entry output FIFO with valid/ready backpressure.
module mem_stream_reader #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      length,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_rdaddress,
    output logic             mem_rden,
    input  logic [WIDTH-1:0] mem_q,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | issuing RAM reads, gated by FIFO room
    // DRAIN | all reads returned, emptying the FIFO
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t           state, state_nx;
    logic [AW-1:0]    base_q;
    logic [AW:0]      len_q;
    logic [AW:0]      issued, issued_nx;
    logic [AW:0]      addr_sum;
    logic             inflight;
    logic             accept;
    logic             done_nx;

    logic [WIDTH-1:0] fifo_mem [3];
    logic [1:0]       rd_ptr, wr_ptr;
    logic [1:0]       fifo_count, fifo_count_nx;
    logic             push, pop;

    assign push      = inflight;
    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE);

    // Gating counts the word still in flight so a full FIFO can never be pushed
    assign mem_rden  = (state == READ) && (issued < len_q) &&
                       ((3'(fifo_count) + 3'(inflight)) < 3'd3);
    assign issued_nx = issued + (AW+1)'(mem_rden);

    assign addr_sum      = {1'b0, base_q} + issued;
    assign mem_rdaddress = (addr_sum >= DEPTH_W) ? AW'(addr_sum - DEPTH_W) : AW'(addr_sum);

    always_comb begin
        fifo_count_nx = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_nx = fifo_count + 2'd1;
            2'b01:   fifo_count_nx = fifo_count - 2'd1;
            default: fifo_count_nx = fifo_count;
        endcase
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (length == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                // Looks at next-cycle issued/inflight so DRAIN starts as the last word lands
                if ((issued_nx == len_q) && !mem_rden)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (fifo_count_nx == 2'd0) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            done     <= done_nx;
            inflight <= mem_rden;
            if (accept) begin
                base_q <= base_addr;
                len_q  <= length;
                issued <= '0;
            end else begin
                issued <= issued_nx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            fifo_count <= 2'd0;
            for (int i = 0; i < 3; i++)
                fifo_mem[i] <= '0;
        end else begin
            fifo_count <= fifo_count_nx;
            if (push) begin
                fifo_mem[wr_ptr] <= mem_q;
                wr_ptr           <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: RAM preloaded mem[i]=i, expected addresses
// and data queued at burst start and compared as the DUT issues reads and transfers.
module tb_mem_stream_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [AW:0]      length;
    logic             busy;
    logic             done;
    logic [AW-1:0]    mem_rdaddress;
    logic             mem_rden;
    logic [WIDTH-1:0] mem_q = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    logic [WIDTH-1:0] ram [DEPTH];
    int               exp_addr[$];
    int               exp_data[$];
    int               errors = 0;
    int               checks = 0;

    mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .mem_rdaddress (mem_rdaddress),
        .mem_rden      (mem_rden),
        .mem_q         (mem_q),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    always #5 clock = ~clock;

    initial for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i);

    always @(posedge clock) if (mem_rden) mem_q <= ram[mem_rdaddress];

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard: every read address and every transfer is matched in order
    always @(negedge clock) begin
        if (reset_n) begin
            if (mem_rden) begin
                if (exp_addr.size() == 0) chk("rden_extra", 1, 0);
                else chk("rd_addr", int'(mem_rdaddress), exp_addr.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) chk("xfer_extra", 1, 0);
                else chk("out_data", int'(out_data), exp_data.pop_front());
            end
        end
    end

    task automatic queue_burst(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            exp_addr.push_back((b + i) % DEPTH);
            exp_data.push_back((b + i) % DEPTH);
        end
    endtask

    task automatic run_burst(input int b, input int l, input int rdy_from,
                             input int exp_done, input int busy_k, input int exp_fv);
        int k, nrden, nxfer, nrden9, first_rden, first_valid, done_k, maxout, stab_err;
        int busy1;
        bit prev_hold;
        logic [WIDTH-1:0] prev_data;
        k = 0; nrden = 0; nxfer = 0; nrden9 = 0; first_rden = -1; first_valid = -1;
        done_k = -1; maxout = 0; stab_err = 0; busy1 = -1; prev_hold = 0; prev_data = '0;
        @(posedge clock); #1;
        start     = 1'b1;
        base_addr = AW'(b);
        length    = (AW+1)'(l);
        out_ready = (rdy_from <= 0);
        queue_burst(b, l);
        while (done_k < 0 && k < 300) begin
            @(negedge clock);
            if (mem_rden) begin
                nrden++;
                if (first_rden < 0) first_rden = k;
            end
            if (out_valid && first_valid < 0) first_valid = k;
            if (prev_hold && out_data !== prev_data) stab_err++;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) nxfer++;
            if (nrden - nxfer > maxout) maxout = nrden - nxfer;
            if (k == 9) nrden9 = nrden;
            if (k == 1) busy1 = int'(busy);
            if (done) done_k = k;
            if (done_k < 0) begin
                @(posedge clock); #1;
                k++;
                start     = (k == busy_k);
                out_ready = (k >= rdy_from);
                if (k == busy_k) begin
                    base_addr = AW'(20);
                    length    = (AW+1)'(3);
                end
            end
        end
        chk("done_cycle", done_k, exp_done);
        chk("rden_count", nrden, l);
        chk("xfer_count", nxfer, l);
        chk("first_valid", first_valid, exp_fv);
        chk("outstanding_le3", int'(maxout <= 3), 1);
        chk("hold_stable", stab_err, 0);
        chk("sb_empty", exp_data.size() + exp_addr.size(), 0);
        if (l > 0) begin
            chk("first_rden", first_rden, 1);
            chk("busy_c1", busy1, 1);
        end
        if (rdy_from >= 10) chk("rden_before_c10", int'(nrden9 <= 3), 1);
        start = 1'b0;
    endtask

    task automatic reset_mid_burst();
        int ndone;
        ndone = 0;
        @(posedge clock); #1;
        start     = 1'b1;
        base_addr = AW'(0);
        length    = (AW+1)'(8);
        out_ready = 1'b1;
        queue_burst(0, 8);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rden", int'(mem_rden), 0);
        chk("rst_addr", int'(mem_rdaddress), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        exp_addr.delete();
        exp_data.delete();
        repeat (2) begin
            @(negedge clock);
            if (done) ndone++;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (done) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        chk("rst_idle", int'(busy), 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b0;
        #3;
        chk("init_busy", int'(busy), 0);
        chk("init_done", int'(done), 0);
        chk("init_rden", int'(mem_rden), 0);
        chk("init_addr", int'(mem_rdaddress), 0);
        chk("init_valid", int'(out_valid), 0);
        chk("init_data", int'(out_data), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        run_burst(4, 5, 0, 8, -1, 3);
        run_burst(62, 4, 0, 7, -1, 3);
        run_burst(0, 8, 10, 18, -1, 3);
        run_burst(0, 0, 0, 2, -1, -1);
        run_burst(0, 64, 0, 67, -1, 3);
        run_burst(0, 10, 0, 13, 4, 3);
        reset_mid_burst();
        run_burst(10, 6, 0, 9, -1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 SHALL have parameters, one per line:
- WIDTH, default 8, data word width.
- DEPTH, default 64, memory word count.
- AW is derived, not overridable: `CLOG2(DEPTH).
REQ-002 SHALL have the following ports, one per line (name, direction, width, meaning):
- clock  in  1  single clock; all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a burst; sampled only in IDLE.
- base_addr  in  AW  first word address; sampled with start.
- length  in  AW+1  word count, 0..DEPTH; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at burst completion.
- mem_rdaddress  out  AW  read address to the synchronous RAM.
- mem_rden  out  1  read enable to the RAM.
- mem_q  in  WIDTH  RAM read data; valid the cycle after mem_rden.
- out_data  out  WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a transfer occurs when out_valid and out_ready are both high.

Function
REQ-003 SHALL implement three states: IDLE, READ and DRAIN.
REQ-004 IDLE: on start=1, SHALL latch base_addr and length. If length=0, SHALL go to DRAIN. Otherwise SHALL go to READ.
REQ-005 READ: SHALL drive mem_rden=1 in a cycle when issued<length and (fifo_count+inflight)<3. SHALL not drive mem_rden=1 otherwise.
REQ-006 mem_rdaddress SHALL equal (base_addr+issued) mod DEPTH. Address SHALL wrap from DEPTH-1 to 0.
REQ-007 inflight SHALL be 1 in the cycle after a mem_rden=1 cycle, else 0. In that cycle mem_q SHALL be written into the output FIFO.
REQ-008 Output FIFO: 3 entries, registered, first-in first-out.
- out_data SHALL be the head entry.
- out_valid SHALL equal (fifo_count>0).
- out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-009 Push and pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
REQ-010 The FIFO SHALL never overflow. Issue gating per REQ-005 guarantees this.
REQ-011 mem_rden SHALL not depend combinationally on out_ready.
REQ-012 Latency: start high in cycle 0 -> first mem_rden in cycle 1 -> first out_valid in cycle 3.
REQ-013 Throughput: with out_ready held high, SHALL sustain one word per cycle. Gap-free output from cycle 3 to cycle 2+length.
REQ-014 READ SHALL transition to DRAIN once issued=length and inflight=0.
REQ-015 DRAIN: when fifo_count=0, SHALL pulse done=1 for exactly one cycle and return to IDLE.
- Next-state of fifo_count counts.
- For length=0, done SHALL pulse in cycle 2 with no mem_rden.
REQ-016 start asserted while busy=1 SHALL be ignored, with no effect on the current burst.
REQ-017 start SHALL be accepted in the cycle after done (IDLE).
REQ-018 mem_rden SHALL never assert in IDLE or DRAIN.
REQ-019 The block SHALL issue exactly length reads and deliver exactly length transfers per burst, in address order.
REQ-020 issued and length counters SHALL be AW+1 bits wide so that length=DEPTH is represented.

Reset
REQ-021 While reset_n=0, asynchronously:
- state=IDLE.
- busy=0, done=0, mem_rden=0, mem_rdaddress=0, out_valid=0, out_data=0.
- fifo_count=0, inflight=0, issued=0.
REQ-022 Reset asserted mid-burst SHALL abort the burst and discard buffered data. No done pulse.
REQ-023 After reset_n deasserts, the block SHALL accept start on the first clock edge.

Verification
REQ-024 SHALL cover: RAM preloaded mem[i]=i, base_addr=4, length=5, out_ready=1.
- Required response: out_data 4,5,6,7,8 in cycles 3..7.
- done in cycle 8.
- 5 mem_rden pulses.
REQ-025 SHALL cover wrap: DEPTH=64, base_addr=62, length=4.
- Required response: addresses 62,63,0,1.
- out_data 62,63,0,1.
REQ-026 SHALL cover backpressure: length=8 with out_ready=0 for cycles 0..9, then 1.
- Required response: at most 3 mem_rden issued before cycle 10; fifo_count never exceeds 3.
- All 8 words arrive in order.
- done follows the 8th transfer.
REQ-027 SHALL cover zero length and full length:
- length=0 -> done in cycle 2, no mem_rden.
- length=64, base_addr=0 -> 64 words, 0..63.
REQ-028 SHALL cover start while busy: a second start with base_addr=20 mid-burst -> ignored; the original stream is unaltered.
REQ-029 SHALL cover reset: reset_n low during cycle 5 of an 8-word burst.
- Required response: all outputs zero immediately; no done.
- A new burst after release completes correctly.
